// File: rtl/ftdi_fifo_arbiter.sv
// Arbiter sharing one FT245-style synchronous FIFO bus between two TX byte
// streams and one RX byte stream, with burst limiting and send-immediate support.
module ftdi_fifo_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = 32
) (
  input  logic             ftdiclk,
  input  logic             reset,
  input  logic             ftdi_rxf_n,
  input  logic             ftdi_txe_n,
  output logic             ftdi_rd_n,
  output logic             ftdi_wr_n,
  output logic             ftdi_oe_n,
  output logic             ftdi_siwu_n,
  inout  wire  [7:0]       ftdi_data,
  input  logic [7:0]       tx0_data,
  input  logic             tx0_valid,
  output logic             tx0_ready,
  input  logic [7:0]       tx1_data,
  input  logic             tx1_valid,
  output logic             tx1_ready,
  input  logic             tx_flush,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] tx_bytes,
  output logic [CNT_W-1:0] rx_bytes
);

  typedef enum logic [1:0] {IDLE, TX, RX_OE, RX} state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_reg, state_next;
  logic       grant_reg, grant_next;     // 0 = TX0, 1 = TX1
  logic       rr_reg, rr_next;           // preferred TX channel when both eligible
  logic       last_rx_reg, last_rx_next; // direction of the most recent grant
  logic       flush_reg, flush_next;
  logic [7:0] burst_reg, burst_next;
  logic [CNT_W-1:0] tx_bytes_reg, rx_bytes_reg;

  logic       tx0_elig, tx1_elig, tx_any, rx_elig;
  logic       tx_g_valid, pick;
  logic [7:0] tx_g_data;
  logic       tx_xfer, rx_xfer, drive_en, last_byte;

  assign tx0_elig   = tx0_valid & ~ftdi_txe_n;
  assign tx1_elig   = tx1_valid & ~ftdi_txe_n;
  assign tx_any     = tx0_elig | tx1_elig;
  assign rx_elig    = ~ftdi_rxf_n & rx_ready;
  assign tx_g_valid = grant_reg ? tx1_valid : tx0_valid;
  assign tx_g_data  = grant_reg ? tx1_data : tx0_data;
  assign last_byte  = (burst_reg == BURST_LAST);
  assign pick       = (tx0_elig & tx1_elig) ? rr_reg : tx1_elig;

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_next      = rr_reg;
    last_rx_next = last_rx_reg;
    flush_next   = flush_reg | tx_flush;
    burst_next   = burst_reg;
    ftdi_rd_n    = 1'b1;
    ftdi_wr_n    = 1'b1;
    ftdi_oe_n    = 1'b1;
    ftdi_siwu_n  = 1'b1;
    tx0_ready    = 1'b0;
    tx1_ready    = 1'b0;
    rx_valid     = 1'b0;
    drive_en     = 1'b0;
    tx_xfer      = 1'b0;
    rx_xfer      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush_reg) begin
          // Send-immediate takes the whole idle cycle; nothing is granted.
          ftdi_siwu_n = 1'b0;
          flush_next  = tx_flush;
        end else if (rx_elig && (!last_rx_reg || !tx_any)) begin
          state_next   = RX_OE;
          last_rx_next = 1'b1;
          burst_next   = 8'd0;
        end else if (tx_any) begin
          state_next   = TX;
          last_rx_next = 1'b0;
          burst_next   = 8'd0;
          grant_next   = pick;
          rr_next      = ~pick;
        end
      end
      TX: begin
        drive_en  = 1'b1;
        tx_xfer   = tx_g_valid & ~ftdi_txe_n;
        ftdi_wr_n = ~tx_xfer;
        tx0_ready = ~grant_reg & ~ftdi_txe_n;
        tx1_ready = grant_reg & ~ftdi_txe_n;
        if (tx_xfer) burst_next = burst_reg + 8'd1;
        if (!tx_g_valid || ftdi_txe_n || last_byte) state_next = IDLE;
      end
      RX_OE: begin
        ftdi_oe_n  = 1'b0;
        state_next = RX;
      end
      RX: begin
        ftdi_oe_n = 1'b0;
        rx_xfer   = rx_ready & ~ftdi_rxf_n;
        ftdi_rd_n = ~rx_xfer;
        rx_valid  = rx_xfer;
        if (rx_xfer) burst_next = burst_reg + 8'd1;
        if (ftdi_rxf_n || !rx_ready || last_byte) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      rr_reg       <= 1'b0;
      last_rx_reg  <= 1'b0;
      flush_reg    <= 1'b0;
      burst_reg    <= 8'd0;
      tx_bytes_reg <= '0;
      rx_bytes_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_reg      <= rr_next;
      last_rx_reg <= last_rx_next;
      flush_reg   <= flush_next;
      burst_reg   <= burst_next;
      if (tx_xfer) tx_bytes_reg <= tx_bytes_reg + CNT_ONE;
      if (rx_xfer) rx_bytes_reg <= rx_bytes_reg + CNT_ONE;
    end
  end

  // The bus is driven only in TX; RX_OE/IDLE give the turnaround cycles.
  assign ftdi_data = drive_en ? tx_g_data : 8'hzz;
  assign rx_data   = ftdi_data;
  assign busy      = (state_reg != IDLE);
  assign tx_bytes  = tx_bytes_reg;
  assign rx_bytes  = rx_bytes_reg;

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Directed bench for ftdi_fifo_arbiter: a behavioural FTDI FIFO and byte sources
// feed the DUT while per-stream scoreboards check every transferred byte.
module tb_ftdi_fifo_arbiter;
  localparam int MB = 4;
  localparam int CW = 8;

  logic ftdiclk = 1'b0;
  logic reset = 1'b1;
  logic ftdi_rxf_n = 1'b1, ftdi_txe_n = 1'b1;
  wire  ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwu_n;
  wire  [7:0] ftdi_data;
  logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
  logic tx0_valid = 1'b0, tx1_valid = 1'b0;
  wire  tx0_ready, tx1_ready;
  logic tx_flush = 1'b0;
  wire  [7:0] rx_data;
  wire  rx_valid;
  logic rx_ready = 1'b0;
  wire  busy;
  wire  [CW-1:0] tx_bytes, rx_bytes;
  logic [7:0] tb_drv = 8'h00;

  assign ftdi_data = ftdi_oe_n ? 8'hzz : tb_drv;

  ftdi_fifo_arbiter #(.MAX_BURST(MB), .CNT_W(CW)) dut (
    .ftdiclk(ftdiclk), .reset(reset),
    .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n), .ftdi_oe_n(ftdi_oe_n), .ftdi_siwu_n(ftdi_siwu_n),
    .ftdi_data(ftdi_data),
    .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_ready(tx0_ready),
    .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
    .tx_flush(tx_flush),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .tx_bytes(tx_bytes), .rx_bytes(rx_bytes)
  );

  always #8 ftdiclk = ~ftdiclk;

  logic [7:0] tx0_src[$], tx1_src[$], rx_src[$];
  logic [7:0] exp0[$], exp1[$], expr[$];
  int burst_type[$], burst_len[$];
  int cur_type, cur_len;
  bit tx0_en, tx1_en, rx_en, txe_block, rx_block, mon_en;
  int checks = 0, errors = 0;
  int wr_cyc, rd_cyc, oe_only_cyc, siwu_cyc;
  logic s_rd_n, s_wr_n, s_oe_n, s_siwu_n, s_busy, s_tx0r, s_tx1r, s_rxv;
  logic [CW-1:0] s_txb, s_rxb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void update_drives();
    tx0_valid  = tx0_en && (tx0_src.size() > 0);
    tx0_data   = tx0_valid ? tx0_src[0] : 8'h00;
    tx1_valid  = tx1_en && (tx1_src.size() > 0);
    tx1_data   = tx1_valid ? tx1_src[0] : 8'h00;
    ftdi_txe_n = txe_block;
    ftdi_rxf_n = rx_block || (rx_src.size() == 0);
    tb_drv     = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
    rx_ready   = rx_en;
  endfunction

  function automatic void note_xfer(input int t);
    if (cur_len > 0 && cur_type != t) begin
      burst_type.push_back(cur_type);
      burst_len.push_back(cur_len);
      cur_len = 0;
    end
    cur_type = t;
    cur_len++;
  endfunction

  // One clock: sample and score at negedge, advance sources at posedge.
  task automatic step();
    bit p0, p1, pr;
    @(negedge ftdiclk);
    s_rd_n = ftdi_rd_n; s_wr_n = ftdi_wr_n; s_oe_n = ftdi_oe_n; s_siwu_n = ftdi_siwu_n;
    s_busy = busy; s_tx0r = tx0_ready; s_tx1r = tx1_ready; s_rxv = rx_valid;
    s_txb = tx_bytes; s_rxb = rx_bytes;
    p0 = !ftdi_wr_n && tx0_ready;
    p1 = !ftdi_wr_n && tx1_ready;
    pr = !ftdi_rd_n;
    if (mon_en) begin
      if (!ftdi_wr_n) begin
        wr_cyc++;
        chk("one_tx_ready", 32'(tx0_ready ^ tx1_ready), 32'd1);
        if (tx0_ready) begin
          chk("exp0_avail", 32'(exp0.size() != 0), 32'd1);
          if (exp0.size() != 0) chk("tx0_bus", 32'(ftdi_data), 32'(exp0.pop_front()));
          note_xfer(1);
        end else if (tx1_ready) begin
          chk("exp1_avail", 32'(exp1.size() != 0), 32'd1);
          if (exp1.size() != 0) chk("tx1_bus", 32'(ftdi_data), 32'(exp1.pop_front()));
          note_xfer(2);
        end
      end
      if (!ftdi_oe_n) begin
        chk("no_wr_when_oe", 32'(ftdi_wr_n), 32'd1);
        chk("bus_from_fifo", 32'(ftdi_data), 32'(tb_drv));
        if (ftdi_rd_n) oe_only_cyc++;
      end
      if (rx_valid) begin
        rd_cyc++;
        chk("rd_n_with_valid", 32'(ftdi_rd_n), 32'd0);
        chk("expr_avail", 32'(expr.size() != 0), 32'd1);
        if (expr.size() != 0) chk("rx_data", 32'(rx_data), 32'(expr.pop_front()));
        note_xfer(0);
      end
      if (!ftdi_siwu_n) begin
        siwu_cyc++;
        chk("siwu_in_idle", 32'(busy), 32'd0);
      end
      if (!busy && cur_len > 0) begin
        burst_type.push_back(cur_type);
        burst_len.push_back(cur_len);
        cur_len = 0;
      end
    end
    @(posedge ftdiclk);
    if (p0 && tx0_src.size() > 0) tx0_src.delete(0);
    if (p1 && tx1_src.size() > 0) tx1_src.delete(0);
    if (pr && rx_src.size() > 0) rx_src.delete(0);
    #1;
    update_drives();
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset = 1'b1;
    tx_flush = 1'b0;
    tx0_src.delete(); tx1_src.delete(); rx_src.delete();
    exp0.delete(); exp1.delete(); expr.delete();
    burst_type.delete(); burst_len.delete();
    cur_len = 0; cur_type = -1;
    tx0_en = 0; tx1_en = 0; rx_en = 0; txe_block = 1; rx_block = 0;
    update_drives();
    step();
    step();
    reset = 1'b0;
    wr_cyc = 0; rd_cyc = 0; oe_only_cyc = 0; siwu_cyc = 0;
    mon_en = 1;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit done = 0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      step();
      if (exp0.size() == 0 && exp1.size() == 0 && expr.size() == 0 && !s_busy) done = 1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_count(input string tag, input int target, input bit use_rd);
    bit hit = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      step();
      if ((use_rd ? rd_cyc : wr_cyc) >= target) hit = 1;
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rd_n", 32'(s_rd_n), 32'd1);
    chk("rst_wr_n", 32'(s_wr_n), 32'd1);
    chk("rst_oe_n", 32'(s_oe_n), 32'd1);
    chk("rst_siwu_n", 32'(s_siwu_n), 32'd1);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_readies", 32'({s_tx0r, s_tx1r, s_rxv}), 32'd0);
    chk("rst_counts", 32'({s_txb, s_rxb}), 32'd0);

    // Three-byte TX0 burst
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx0_src.push_back(8'(8'h45 + i)); exp0.push_back(8'(8'h45 + i));
    end
    tx0_en = 1; txe_block = 0; update_drives();
    wait_done("tx3", 40);
    chk("tx3_wr_cycles", 32'(wr_cyc), 32'd3);
    chk("tx3_tx_bytes", 32'(s_txb), 32'd3);
    chk("tx3_bursts", 32'(burst_len.size()), 32'd1);

    // Four-byte RX burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx_src.push_back(8'(8'hA0 + i)); expr.push_back(8'(8'hA0 + i));
    end
    rx_en = 1; update_drives();
    wait_done("rx4", 40);
    chk("rx4_oe_only", 32'(oe_only_cyc), 32'd1);
    chk("rx4_beats", 32'(rd_cyc), 32'd4);
    chk("rx4_oe_after", 32'(s_oe_n), 32'd1);
    chk("rx4_rx_bytes", 32'(s_rxb), 32'd4);

    // Everyone eligible: alternating direction, round-robin TX
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tx0_src.push_back(8'(8'h10 + i)); exp0.push_back(8'(8'h10 + i));
      tx1_src.push_back(8'(8'h20 + i)); exp1.push_back(8'(8'h20 + i));
      rx_src.push_back(8'(8'h30 + i));  expr.push_back(8'(8'h30 + i));
    end
    tx0_en = 1; tx1_en = 1; rx_en = 1; txe_block = 0; update_drives();
    for (int n = 0; n < 200 && burst_type.size() < 4; n++) step();
    chk("arb_burst_count", 32'(burst_type.size() >= 4), 32'd1);
    if (burst_type.size() >= 4) begin
      chk("arb_g0_rx", 32'(burst_type[0]), 32'd0);
      chk("arb_g1_tx0", 32'(burst_type[1]), 32'd1);
      chk("arb_g2_rx", 32'(burst_type[2]), 32'd0);
      chk("arb_g3_tx1", 32'(burst_type[3]), 32'd2);
      for (int b = 0; b < 4; b++) chk($sformatf("arb_len%0d", b), 32'(burst_len[b]), 32'(MB));
    end

    // TX space disappears mid-burst, resumes later
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx0_src.push_back(8'(8'h50 + i)); exp0.push_back(8'(8'h50 + i));
    end
    tx0_en = 1; txe_block = 0; update_drives();
    wait_count("stall", 2, 0);
    txe_block = 1; update_drives();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wr_n", 32'(s_wr_n), 32'd1);
      chk("stall_tx0_ready", 32'(s_tx0r), 32'd0);
    end
    txe_block = 0; update_drives();
    wait_done("stall", 60);
    chk("stall_wr_cycles", 32'(wr_cyc), 32'd5);
    chk("stall_tx_bytes", 32'(s_txb), 32'd5);

    // Flush requested during a TX burst
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx0_src.push_back(8'(8'h60 + i)); exp0.push_back(8'(8'h60 + i));
    end
    tx0_en = 1; txe_block = 0; update_drives();
    wait_count("flush", 1, 0);
    tx_flush = 1'b1;
    step();
    tx_flush = 1'b0;
    wait_done("flush", 40);
    repeat (4) step();
    chk("flush_siwu_cycles", 32'(siwu_cyc), 32'd1);
    chk("flush_wr_cycles", 32'(wr_cyc), 32'd3);

    // Reset in the middle of an RX burst
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rx_src.push_back(8'(8'h70 + i)); expr.push_back(8'(8'h70 + i));
    end
    rx_en = 1; update_drives();
    wait_count("rxrst", 2, 1);
    reset = 1'b1;
    step();
    step();
    chk("rxrst_strobes", 32'({s_rd_n, s_wr_n, s_oe_n, s_siwu_n}), 32'hF);
    chk("rxrst_busy", 32'(s_busy), 32'd0);
    chk("rxrst_rx_valid", 32'(s_rxv), 32'd0);
    chk("rxrst_counts", 32'({s_txb, s_rxb}), 32'd0);

    // Counter wrap: 260 bytes through an 8-bit counter
    do_reset();
    for (int i = 0; i < 260; i++) begin
      rx_src.push_back(8'(i)); expr.push_back(8'(i));
    end
    rx_en = 1; update_drives();
    wait_done("wrap", 1000);
    chk("wrap_rx_bytes", 32'(s_rxb), 32'd4);
    chk("wrap_beats", 32'(rd_cyc), 32'd260);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
